// File: rtl/msx_mouse_pkg.sv
// Shared types and limits for the MSX mouse port.
// Nibble sequencer states, default timeout and saturation bounds.
package msx_mouse_pkg;

  typedef enum logic [1:0] {
    NIB_XH,
    NIB_XL,
    NIB_YH,
    NIB_YL
  } nib_e;

  localparam int TIMEOUT_DEFAULT = 100000;

  localparam logic signed [9:0] SAT_MAX = 10'sd127;
  localparam logic signed [9:0] SAT_MIN = -10'sd128;

endpackage

// File: rtl/msx_mouse_satacc.sv
// 8-bit signed saturating accumulator with clear and add.
// Clear and add together load the delta into a zeroed accumulator.
module msx_mouse_satacc
  import msx_mouse_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add,
  input  logic signed [9:0] delta,
  output logic signed [7:0] acc
);

  logic signed [9:0] base;
  logic signed [9:0] sum;
  logic signed [7:0] sat;

  always_comb begin
    base = clr ? 10'sd0 : {{2{acc[7]}}, acc};
    sum  = base + delta;
    sat  = sum[7:0];
    if (sum > SAT_MAX)
      sat = SAT_MAX[7:0];
    else if (sum < SAT_MIN)
      sat = SAT_MIN[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (add)
      acc <= sat;
    else if (clr)
      acc <= '0;
  end

endmodule

// File: rtl/msx_mouse_port.sv
// MSX port-A mouse emulation: accumulates user_io motion and
// serves it as four nibbles clocked out by the stra toggles.
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] mouse_x,
  input  logic [8:0] mouse_y,
  input  logic [7:0] mouse_flags,
  input  logic       mouse_strobe,
  input  logic       joy_active,
  input  logic       stra,
  output logic       mouse_en,
  output logic [5:0] mouse_pins
);

  localparam int CW = $clog2(TIMEOUT + 1);

  nib_e          state;
  nib_e          state_nx;
  logic          stra_d;
  logic          toggle;
  logic          adv;
  logic          timeout_hit;
  logic          snap;
  logic          en_nx;
  logic          clr;
  logic [CW-1:0] cnt;
  logic [3:0]    nib_nx;
  logic [7:0]    acc_x;
  logic [7:0]    acc_y;
  logic [7:0]    tx_x;
  logic [7:0]    tx_y;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic          flags_unused;

  assign flags_unused = ^mouse_flags[7:2];

  assign toggle      = stra ^ stra_d;
  assign adv         = toggle & mouse_en;
  assign timeout_hit = mouse_en & ~toggle & (cnt == CW'(1));
  assign en_nx       = mouse_strobe | (mouse_en & ~joy_active);
  assign clr         = ~mouse_en | snap;
  assign dx          = -{mouse_x[8], mouse_x};
  assign dy          = {mouse_y[8], mouse_y};

  // Strobe edge detect runs through reset so no stale toggle appears.
  always_ff @(posedge clk_sys)
    stra_d <= stra;

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= NIB_XH;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!mouse_en)
      state_nx = NIB_XH;
    else if (adv) begin
      unique case (state)
        NIB_XH: state_nx = NIB_XL;
        NIB_XL: state_nx = NIB_YH;
        NIB_YH: state_nx = NIB_YL;
        NIB_YL: state_nx = NIB_XH;
      endcase
    end else if (timeout_hit)
      state_nx = NIB_XH;
  end

  // The XH nibble comes straight from the accumulator being snapshotted.
  always_comb begin
    snap   = adv & (state == NIB_XH);
    nib_nx = mouse_pins[3:0];
    if (!en_nx)
      nib_nx = 4'hF;
    else if (adv) begin
      unique case (state)
        NIB_XH: nib_nx = acc_x[7:4];
        NIB_XL: nib_nx = tx_x[3:0];
        NIB_YH: nib_nx = tx_y[7:4];
        NIB_YL: nib_nx = tx_y[3:0];
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mouse_en   <= 1'b0;
      mouse_pins <= 6'h3F;
      tx_x       <= '0;
      tx_y       <= '0;
      cnt        <= '0;
    end else begin
      mouse_en        <= en_nx;
      mouse_pins[5:4] <= ~mouse_flags[1:0];
      mouse_pins[3:0] <= nib_nx;
      if (snap) begin
        tx_x <= acc_x;
        tx_y <= acc_y;
      end
      if (!mouse_en)
        cnt <= '0;
      else if (toggle)
        cnt <= CW'(TIMEOUT);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  msx_mouse_satacc u_acc_x (
    .clk   (clk_sys),
    .reset (reset),
    .clr   (clr),
    .add   (mouse_strobe),
    .delta (dx),
    .acc   (acc_x)
  );

  msx_mouse_satacc u_acc_y (
    .clk   (clk_sys),
    .reset (reset),
    .clr   (clr),
    .add   (mouse_strobe),
    .delta (dy),
    .acc   (acc_y)
  );

endmodule

// File: tb/tb_msx_mouse_port.sv
// Directed self-checking bench for msx_mouse_port.
// Short TIMEOUT keeps the timeout scenarios quick.
module tb_msx_mouse_port;

  localparam int TO = 20;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [8:0] mouse_x;
  logic [8:0] mouse_y;
  logic [7:0] mouse_flags;
  logic       mouse_strobe;
  logic       joy_active;
  logic       stra;
  logic       mouse_en;
  logic [5:0] mouse_pins;

  int checks = 0;
  int failures = 0;

  msx_mouse_port #(.TIMEOUT(TO)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .mouse_flags  (mouse_flags),
    .mouse_strobe (mouse_strobe),
    .joy_active   (joy_active),
    .stra         (stra),
    .mouse_en     (mouse_en),
    .mouse_pins   (mouse_pins)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [8:0] x, input logic [8:0] y);
    mouse_x = x;
    mouse_y = y;
    mouse_strobe = 1'b1;
    cyc();
    mouse_strobe = 1'b0;
    mouse_x = '0;
    mouse_y = '0;
  endtask

  task automatic toggle();
    stra = ~stra;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    checks++;
    if (mouse_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_en got=%b exp=0", mouse_en);
    end
    checks++;
    if (mouse_pins !== 6'h3F) begin
      failures++;
      $display("FAIL reset_pins got=%h exp=3f", mouse_pins);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    logic [3:0] exp [4];
    exp = '{4'hF, 4'hB, 4'hF, 4'hD};
    strobe(9'd5, 9'h1FD);
    checks++;
    if (mouse_en !== 1'b1) begin
      failures++;
      $display("FAIL basic_en got=%b exp=1", mouse_en);
    end
    for (int i = 0; i < 4; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL basic_nib%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp [8];
    exp = '{4'h8, 4'h0, 4'h0, 4'h0,
            4'h7, 4'hF, 4'h0, 4'h0};
    repeat (3) strobe(9'd100, 9'd0);
    for (int i = 0; i < 4; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL sat_neg_nib%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
    repeat (3) strobe(9'h19C, 9'd0);
    for (int i = 4; i < 8; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL sat_pos_nib%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
  endtask

  task automatic test_buttons();
    logic [7:0] fl [3];
    logic [1:0] exp [3];
    fl  = '{8'hFD, 8'h02, 8'h00};
    exp = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      mouse_flags = fl[i];
      cyc();
      checks++;
      if (mouse_pins[5:4] !== exp[i]) begin
        failures++;
        $display("FAIL buttons%0d got=%b exp=%b",
                 i, mouse_pins[5:4], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp [5];
    exp = '{4'hF, 4'hD, 4'h0, 4'h4, 4'h3};
    strobe(9'd3, 9'd0);
    for (int i = 0; i < 2; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL to_pre%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
    strobe(9'h1FC, 9'h035);
    repeat (TO) cyc();
    for (int i = 2; i < 5; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL to_post%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
    // toggle lands on the cycle the counter reaches 1
    repeat (TO - 1) cyc();
    toggle();
    checks++;
    if (mouse_pins[3:0] !== 4'h5) begin
      failures++;
      $display("FAIL to_priority got=%h exp=5", mouse_pins[3:0]);
    end
  endtask

  task automatic test_joy();
    joy_active = 1'b1;
    strobe(9'd0, 9'd0);
    checks++;
    if (mouse_en !== 1'b1) begin
      failures++;
      $display("FAIL joy_same got=%b exp=1", mouse_en);
    end
    cyc();
    checks++;
    if (mouse_en !== 1'b0) begin
      failures++;
      $display("FAIL joy_alone_en got=%b exp=0", mouse_en);
    end
    checks++;
    if (mouse_pins[3:0] !== 4'hF) begin
      failures++;
      $display("FAIL joy_alone_nib got=%h exp=f", mouse_pins[3:0]);
    end
    joy_active = 1'b0;
    toggle();
    checks++;
    if (mouse_pins !== 6'h3F) begin
      failures++;
      $display("FAIL joy_idle_pins got=%h exp=3f", mouse_pins);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp [4];
    exp = '{4'hF, 4'h0, 4'h2, 4'h1};
    strobe(9'h010, 9'd0);
    for (int i = 0; i < 2; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL rmid_pre%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
    mouse_flags = 8'h03;
    cyc();
    reset = 1'b1;
    stra = ~stra;
    cyc();
    checks++;
    if (mouse_en !== 1'b0 || mouse_pins !== 6'h3F) begin
      failures++;
      $display("FAIL rmid_reset got=%b/%h exp=0/3f",
               mouse_en, mouse_pins);
    end
    mouse_flags = 8'h00;
    cyc();
    reset = 1'b0;
    cyc();
    strobe(9'h1DF, 9'd0);
    for (int i = 2; i < 4; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL rmid_post%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [6];
    exp = '{4'hD, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
    toggle();
    toggle();
    strobe(9'd3, 9'd0);
    mouse_x = 9'h1FE;
    mouse_strobe = 1'b1;
    stra = ~stra;
    cyc();
    mouse_strobe = 1'b0;
    mouse_x = '0;
    checks++;
    if (mouse_pins[3:0] !== 4'hF) begin
      failures++;
      $display("FAIL b2b_old got=%h exp=f", mouse_pins[3:0]);
    end
    for (int i = 0; i < 5; i++) begin
      toggle();
      checks++;
      if (mouse_pins[3:0] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_nib%0d got=%h exp=%h",
                 i, mouse_pins[3:0], exp[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mouse_x = '0;
    mouse_y = '0;
    mouse_flags = '0;
    mouse_strobe = 1'b0;
    joy_active = 1'b0;
    stra = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_buttons();
    test_timeout();
    test_joy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msx_mouse_port.md
MSX_MOUSE_PORT -- requirements
Module: msx_mouse_port

Interface
REQ-001 Parameter: TIMEOUT, 100000, clk_sys cycles without a strobe toggle before the nibble sequence returns to the first nibble.
REQ-002 clk_sys  in  1  system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mouse_x  in  9  signed two's-complement X delta from user_io.
REQ-005 mouse_y  in  9  signed two's-complement Y delta from user_io.
REQ-006 mouse_flags  in  8  bit0 = left button, bit1 = right button; other bits ignored.
REQ-007 mouse_strobe  in  1  one-cycle pulse; mouse_x, mouse_y and mouse_flags are valid in that cycle.
REQ-008 joy_active  in  1  high while any joystick-A direction or button is pressed.
REQ-009 stra  in  1  MSX port-A strobe (pin 8) from the emsx core, already in the clk_sys domain.
REQ-010 mouse_en  out  1  high while the mouse owns port A.
REQ-011 mouse_pins  out  6  active-low port-A levels: [3:0] data nibble, [4] left button, [5] right button.

Function
REQ-012 mouse_en SHALL be set in the cycle after any mouse_strobe, and cleared in the cycle after joy_active=1 with mouse_strobe=0; when both occur in the same cycle, mouse_strobe SHALL win.
REQ-013 mouse_pins[5:4] SHALL register ~mouse_flags[1:0] every cycle, with 1-cycle latency, independent of mouse_en.
REQ-014 Two accumulators SHALL be kept: acc_x accumulates the negated mouse_x and acc_y accumulates mouse_y on each mouse_strobe; both are 8-bit signed.
REQ-015 Accumulation SHALL use a 10-bit intermediate and saturate to [-128,+127]; it SHALL never wrap.
REQ-016 stra_d SHALL register stra every cycle, including during reset; a toggle is stra != stra_d.
REQ-017 The sequencer SHALL have states NIB_XH, NIB_XL, NIB_YH, NIB_YL; each toggle while mouse_en=1 SHALL advance it one state, wrapping from NIB_YL to NIB_XH.
REQ-018 A toggle in NIB_XH SHALL snapshot acc_x/acc_y into tx_x/tx_y and clear both accumulators in the same cycle; a mouse_strobe in that cycle SHALL load its own delta into the cleared accumulators.
REQ-019 The nibble driven after each toggle SHALL be: from NIB_XH tx_x[7:4], from NIB_XL tx_x[3:0], from NIB_YH tx_y[7:4], from NIB_YL tx_y[3:0]; it SHALL appear on mouse_pins[3:0] one cycle after the toggle.
REQ-020 Each toggle SHALL load the timeout counter with TIMEOUT; the counter SHALL decrement each cycle while non-zero; on the transition 1->0, state SHALL return to NIB_XH and the accumulators SHALL be retained.
REQ-021 A toggle in the same cycle as the counter reaching 1 SHALL take priority over the timeout.
REQ-022 While mouse_en=0, the accumulators SHALL be held at 0, the state SHALL be held at NIB_XH, the timeout counter SHALL be held at 0, and mouse_pins[3:0] SHALL be held at 4'hF.

Reset
REQ-023 Reset SHALL set: mouse_en=0, mouse_pins=6'h3F, state=NIB_XH, acc_x=acc_y=tx_x=tx_y=0, timeout counter=0.
REQ-024 Reset asserted mid-sequence SHALL discard the transfer, and the first toggle after reset SHALL be decoded as NIB_XH.

Structure
REQ-025 A shared package, msx_mouse_pkg, SHALL hold the state enum, TIMEOUT_DEFAULT, and the saturation limits.
REQ-026 One sub-module, msx_mouse_satacc, SHALL implement the 8-bit saturating accumulator with clear and add; it SHALL be instantiated twice.

Verification
REQ-027 Strobe with x=+5, y=-3, then 4 stra toggles -> nibbles F,B,F,D (tx_x=-5=0xFB, tx_y=0xFD).
REQ-028 Strobe with x=+100 three times -> acc_x saturates at -128, and the sequence yields nibbles 8,0 for X.
REQ-029 Two toggles, then idle TIMEOUT+1 cycles, then one toggle -> the third toggle is decoded as NIB_XH with a new snapshot.
REQ-030 mouse_strobe and joy_active in the same cycle -> mouse_en=1; joy_active alone next cycle -> mouse_en=0 and mouse_pins[3:0]=F.
REQ-031 Reset asserted after the NIB_XL toggle -> all outputs reach reset values, and the next toggle outputs the X high nibble.
REQ-032 Toggle coincident with mouse_strobe x=-2 in NIB_XH -> old motion is sent, and acc_x=+2 afterwards.
